// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the BCD stopwatch: run-state encoding, digit width
// and per-digit wrap values.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int PRESCALE_W = 10;

  localparam logic [DIGIT_W-1:0] SEC_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_ONES_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] MIN_TENS_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit that counts 0..MAX and wraps; o_carry flags the increment that wraps
// it, so digits can be chained.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = 4'd9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_inc,
  output logic [DIGIT_W-1:0] o_value,
  output logic               o_carry
);

  logic [DIGIT_W-1:0] value_q;

  // NOTE: clocked state uses non-blocking assignments, so every register in the chain
  // samples the pre-edge value of its neighbour.
  always_ff @(posedge i_clk) begin
    if (!i_reset || i_clear) begin
      value_q <= '0;
    end else if (i_inc) begin
      value_q <= (value_q == MAX) ? '0 : value_q + 1'b1;
    end
  end

  assign o_value = value_q;
  assign o_carry = i_inc && (value_q == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch. It counts rising edges of i_frequency while in RUN, divided down
// by a prescaler, and is controlled by clear/stop/start level commands.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_frequency,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_clear,
  output logic [DIGIT_W-1:0] o_sec_ones,
  output logic [DIGIT_W-1:0] o_sec_tens,
  output logic [DIGIT_W-1:0] o_min_ones,
  output logic [DIGIT_W-1:0] o_min_tens,
  output logic               o_running,
  output logic               o_tick,
  output logic               o_rollover
);

  localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICKS_PER_SECOND - 1);

  state_t                  state_q, state_d;
  logic                    freq_q;
  logic                    freq_edge;
  logic                    count_en;
  logic                    sec_adv;
  logic [PRESCALE_W-1:0]   presc_q;
  logic [3:0]              carry;

  assign freq_edge = i_frequency & ~freq_q;
  // An edge arriving in the same cycle as a stop or clear is dropped, not deferred.
  assign count_en  = (state_q == RUN) && freq_edge && !i_clear && !i_stop;
  assign sec_adv   = count_en && (presc_q == PRESC_LAST);

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else if (i_stop) begin
      if (state_q == RUN) state_d = PAUSE;
    end else if (i_start) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= IDLE;
      freq_q     <= 1'b0;
      presc_q    <= '0;
      o_running  <= 1'b0;
      o_tick     <= 1'b0;
      o_rollover <= 1'b0;
    end else begin
      state_q    <= state_d;
      freq_q     <= i_frequency;
      o_running  <= (state_d == RUN);
      o_tick     <= freq_edge;
      o_rollover <= carry[3];
      if (i_clear) begin
        presc_q <= '0;
      end else if (count_en) begin
        presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      end
    end
  end

  bcd_digit #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_inc(sec_adv), .o_value(o_sec_ones), .o_carry(carry[0])
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_inc(carry[0]), .o_value(o_sec_tens), .o_carry(carry[1])
  );

  bcd_digit #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_inc(carry[1]), .o_value(o_min_ones), .o_carry(carry[2])
  );

  bcd_digit #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear),
    .i_inc(carry[2]), .o_value(o_min_tens), .o_carry(carry[3])
  );

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd. It runs two instances (1 and 4 ticks per second) under
// directed and random stimulus against an elapsed-tick reference model.
module tb_stopwatch_bcd;

  logic clk;
  logic rst_in, freq_in, start_in, stop_in, clear_in;

  logic [3:0] a_so, a_st, a_mo, a_mt, b_so, b_st, b_mo, b_mt;
  logic       a_run, a_tick, a_roll, b_run, b_tick, b_roll;

  stopwatch_bcd #(.TICKS_PER_SECOND(1)) u_dut_a (
    .i_clk(clk), .i_reset(rst_in), .i_frequency(freq_in),
    .i_start(start_in), .i_stop(stop_in), .i_clear(clear_in),
    .o_sec_ones(a_so), .o_sec_tens(a_st), .o_min_ones(a_mo), .o_min_tens(a_mt),
    .o_running(a_run), .o_tick(a_tick), .o_rollover(a_roll)
  );

  stopwatch_bcd #(.TICKS_PER_SECOND(4)) u_dut_b (
    .i_clk(clk), .i_reset(rst_in), .i_frequency(freq_in),
    .i_start(start_in), .i_stop(stop_in), .i_clear(clear_in),
    .o_sec_ones(b_so), .o_sec_tens(b_st), .o_min_ones(b_mo), .o_min_tens(b_mt),
    .o_running(b_run), .o_tick(b_tick), .o_rollover(b_roll)
  );

  wire [15:0] a_time = {a_mt, a_mo, a_st, a_so};
  wire [15:0] b_time = {b_mt, b_mo, b_st, b_so};
  wire [18:0] a_vec  = {a_time, a_run, a_tick, a_roll};
  wire [18:0] b_vec  = {b_time, b_run, b_tick, b_roll};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int tick_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed counted edges since the last clear, plus a run mode.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int m_tps   [2] = '{1, 4};
  int m_mode  [2];
  int m_count [2];
  int m_fprev [2];
  int m_tick  [2];
  int m_roll  [2];

  task automatic model_update(input logic f, st, sp, cl, rst);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_mode[i] = M_IDLE; m_count[i] = 0; m_fprev[i] = 0;
        m_tick[i] = 0;      m_roll[i]  = 0;
      end else begin
        int edge_seen;
        int was_run;
        edge_seen  = (f && m_fprev[i] == 0) ? 1 : 0;
        was_run    = (m_mode[i] == M_RUN) ? 1 : 0;
        m_fprev[i] = f ? 1 : 0;
        m_tick[i]  = edge_seen;
        m_roll[i]  = 0;
        if (cl) begin
          m_mode[i] = M_IDLE; m_count[i] = 0;
        end else if (sp) begin
          if (m_mode[i] == M_RUN) m_mode[i] = M_PAUSE;
        end else if (st) begin
          m_mode[i] = M_RUN;
        end
        if (was_run == 1 && edge_seen == 1 && !cl && !sp) begin
          m_count[i]++;
          if (m_count[i] == 3600 * m_tps[i]) begin
            m_count[i] = 0;
            m_roll[i]  = 1;
          end
        end
      end
    end
  endtask

  function automatic logic [18:0] exp_vec(input int i);
    int secs, s, m;
    secs = m_count[i] / m_tps[i];
    s    = secs % 60;
    m    = secs / 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
            (m_mode[i] == M_RUN) ? 1'b1 : 1'b0, 1'(m_tick[i]), 1'(m_roll[i])};
  endfunction

  task automatic step(input logic f, st, sp, cl, rst);
    freq_in = f; start_in = st; stop_in = sp; clear_in = cl; rst_in = rst;
    @(posedge clk);
    model_update(f, st, sp, cl, rst);
    #1;
    check("model_a", 32'(a_vec), 32'(exp_vec(0)));
    check("model_b", 32'(b_vec), 32'(exp_vec(1)));
  endtask

  task automatic edges(input int n);
    for (int k = 0; k < n; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick_cnt += int'(a_tick);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick_cnt += int'(a_tick);
    end
  endtask

  task automatic clear_and_start();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    freq_in = 0; start_in = 0; stop_in = 0; clear_in = 0; rst_in = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_a", 32'(a_vec), 32'd0);
    check("reset_b", 32'(b_vec), 32'd0);

    // Ten edges at one tick per second.
    clear_and_start();
    tick_cnt = 0;
    edges(10);
    check("ten_edges_time", 32'(a_time), 32'h0010);
    check("ten_edges_ticks", 32'(tick_cnt), 32'd10);

    // Four ticks per second: 7 edges -> 00:01, one more -> 00:02.
    clear_and_start();
    edges(7);
    check("tps4_seven", 32'(b_time), 32'h0001);
    edges(1);
    check("tps4_eight", 32'(b_time), 32'h0002);

    // Stop coincident with an edge at 00:05.
    clear_and_start();
    edges(5);
    check("stop_pre", 32'(a_time), 32'h0005);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("stop_time", 32'(a_time), 32'h0005);
    check("stop_run", 32'(a_run), 32'd0);
    check("stop_tick", 32'(a_tick), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    edges(1);
    check("resume_time", 32'(a_time), 32'h0006);

    // All commands at once at 12:34.
    clear_and_start();
    edges(754);
    check("at_1234", 32'(a_time), 32'h1234);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("all_cmd_time", 32'(a_time), 32'h0000);
    check("all_cmd_run", 32'(a_run), 32'd0);

    // One-cycle reset at 03:07 while running.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    edges(187);
    check("at_0307", 32'(a_time), 32'h0307);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("midrun_reset", 32'(a_vec), 32'd0);
    edges(3);
    check("post_reset_idle", 32'(a_time), 32'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    edges(1);
    check("post_reset_run", 32'(a_time), 32'h0001);

    // Wrap from 59:59.
    clear_and_start();
    edges(3598);
    check("at_5958", 32'(a_time), 32'h5958);
    edges(1);
    check("at_5959", 32'(a_time), 32'h5959);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_time", 32'(a_time), 32'h0000);
    check("wrap_roll", 32'(a_roll), 32'd1);
    check("wrap_run", 32'(a_run), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("wrap_roll_pulse", 32'(a_roll), 32'd0);

    // Random command and frequency traffic.
    for (int c = 0; c < 4000; c++) begin
      logic f, st, sp, cl, rst;
      f   = ($urandom_range(0, 99) < 45);
      st  = ($urandom_range(0, 99) < 12);
      sp  = ($urandom_range(0, 99) < 4);
      cl  = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 199) != 0);
      step(f, st, sp, cl, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter TICKS_PER_SECOND, default 1: number of rising edges of i_frequency per counted second; legal range 1..1023.
REQ-002 i_clk  input  1  system clock; all logic on its rising edge.
REQ-003 i_reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising i_clk).
REQ-004 i_frequency  input  1  divided square wave from the clock divider, synchronous to i_clk.
REQ-005 i_start  input  1  level; when 1, requests the RUN state.
REQ-006 i_stop  input  1  level; when 1, requests the PAUSE state.
REQ-007 i_clear  input  1  level; when 1, zeroes the time and enters IDLE.
REQ-008 o_sec_ones  output  4  BCD seconds units, 0..9.
REQ-009 o_sec_tens  output  4  BCD seconds tens, 0..5.
REQ-010 o_min_ones  output  4  BCD minutes units, 0..9.
REQ-011 o_min_tens  output  4  BCD minutes tens, 0..5.
REQ-012 o_running  output  1  1 while the state is RUN.
REQ-013 o_tick  output  1  one-cycle pulse per detected rising edge of i_frequency.
REQ-014 o_rollover  output  1  one-cycle pulse when the count wraps from 59:59 to 00:00.

Function
REQ-015 Register freq_q <= i_frequency every cycle; edge = i_frequency & ~freq_q.
REQ-016 o_tick is edge registered; it is high exactly 1 cycle, 1 cycle after i_frequency is first sampled high, regardless of state.
REQ-017 States: IDLE, RUN, PAUSE.
REQ-018 Command priority is i_clear > i_stop > i_start, evaluated every cycle.
REQ-019 i_clear: next state IDLE; prescaler and all digits go to 0 next cycle; an edge in the same cycle is discarded.
REQ-020 i_stop in RUN goes to PAUSE; in IDLE or PAUSE it has no effect.
REQ-021 i_start in IDLE or PAUSE goes to RUN; in RUN it has no effect.
REQ-022 Edges are counted only when the state is RUN in that cycle and neither i_clear nor i_stop is asserted.
REQ-023 Prescaler width is 10 bits; a counted edge increments it; at TICKS_PER_SECOND-1 it wraps to 0 and advances seconds in the same cycle.
REQ-024 Digit carry chain: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 wraps.
REQ-025 At 59:59, an advance produces 00:00, o_rollover=1 for 1 cycle, and the state stays RUN.
REQ-026 Digit outputs are registered; the new value is visible 1 cycle after the edge cycle, aligned with o_tick.
REQ-027 PAUSE holds the prescaler and digits; resuming with RUN continues from the held prescaler value.
REQ-028 o_running is registered and equals (state==RUN).

Reset
REQ-029 While i_reset==0 at a clock edge: state IDLE, freq_q=0, prescaler=0, all digits 0, o_running=0, o_tick=0, o_rollover=0.
REQ-030 Reset during RUN aborts counting; the first edge counted after release requires i_start first.
REQ-031 No output or state changes asynchronously.

Structure
REQ-032 Shared package stopwatch_pkg holds the state enum (IDLE, RUN, PAUSE), the BCD digit width (4) and the limits SEC_TENS_MAX=5 and MIN_TENS_MAX=5.
REQ-033 Sub-module bcd_digit holds one digit: parameter MAX; inputs i_clk, i_reset, i_clear, i_inc; outputs o_value and o_carry (i_inc & value==MAX); instantiated 4 times in a chain.

Verification
REQ-034 TICKS_PER_SECOND=1, i_start pulse, then 10 edges -> o_sec_tens=1, o_sec_ones=0, 10 o_tick pulses.
REQ-035 TICKS_PER_SECOND=4, RUN, 7 edges -> time 00:01, prescaler=3; the next edge -> 00:02.
REQ-036 Run to 59:58, then 2 edges -> 59:59, then 00:00 with o_rollover high 1 cycle and o_running still 1.
REQ-037 i_stop asserted in the same cycle as an edge at 00:05 -> time stays 00:05, state PAUSE, o_tick still pulses; i_start plus 1 edge -> 00:06.
REQ-038 i_clear, i_stop and i_start all high at 12:34 -> next cycle 00:00, IDLE, o_running=0.
REQ-039 i_reset=0 for 1 cycle mid-RUN at 03:07 -> all outputs 0 next cycle; edges ignored until i_start.
